// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI timing generator: counters, sync/blank/DE decode, FIFO fetch and frame pulses.
// Optional internal test pattern enabled by defining VGA_TIMING_TEST_PICTURE_EN.
module vga_timing_gen #(
  parameter int c_resolution_x      = 640,
  parameter int c_hsync_front_porch = 16,
  parameter int c_hsync_pulse       = 96,
  parameter int c_hsync_back_porch  = 48,
  parameter int c_resolution_y      = 480,
  parameter int c_vsync_front_porch = 10,
  parameter int c_vsync_pulse       = 2,
  parameter int c_vsync_back_porch  = 33,
  parameter int c_hsync_pol         = 1,
  parameter int c_vsync_pol         = 1,
  parameter int c_bits_x            = 12,
  parameter int c_bits_y            = 11,
  parameter int c_dbl_x             = 0,
  parameter int c_dbl_y             = 0
) (
  input  logic                clk_pixel,
  input  logic                rst_n,
  input  logic                clk_pixel_ena,
  input  logic                test_picture,
  input  logic [7:0]          r_i,
  input  logic [7:0]          g_i,
  input  logic [7:0]          b_i,
  output logic                fetch_next,
  output logic                line_repeat,
  output logic [c_bits_x-1:0] beam_x,
  output logic [c_bits_y-1:0] beam_y,
  output logic                frame_start,
  output logic                vblank_irq,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_blank,
  output logic                vga_vblank,
  output logic                vga_de
);

  localparam int FRAME_X = c_resolution_x + c_hsync_front_porch + c_hsync_pulse + c_hsync_back_porch;
  localparam int FRAME_Y = c_resolution_y + c_vsync_front_porch + c_vsync_pulse + c_vsync_back_porch;

  localparam logic [c_bits_x-1:0] X_RES   = c_bits_x'(c_resolution_x);
  localparam logic [c_bits_x-1:0] X_LAST  = c_bits_x'(FRAME_X - 1);
  localparam logic [c_bits_x-1:0] HS_BEG  = c_bits_x'(c_resolution_x + c_hsync_front_porch);
  localparam logic [c_bits_x-1:0] HS_END  = c_bits_x'(c_resolution_x + c_hsync_front_porch + c_hsync_pulse - 1);
  localparam logic [c_bits_y-1:0] Y_RES   = c_bits_y'(c_resolution_y);
  localparam logic [c_bits_y-1:0] Y_LAST  = c_bits_y'(FRAME_Y - 1);
  localparam logic [c_bits_y-1:0] Y_VBEG  = c_bits_y'(c_resolution_y - 1);
  localparam logic [c_bits_y-1:0] VS_BEG  = c_bits_y'(c_resolution_y + c_vsync_front_porch);
  localparam logic [c_bits_y-1:0] VS_END  = c_bits_y'(c_resolution_y + c_vsync_front_porch + c_vsync_pulse - 1);
  localparam logic HPOL  = (c_hsync_pol != 0);
  localparam logic VPOL  = (c_vsync_pol != 0);
  localparam logic DBL_X = (c_dbl_x != 0);
  localparam logic DBL_Y = (c_dbl_y != 0);

  logic [c_bits_x-1:0] x_q, x_d;
  logic [c_bits_y-1:0] y_q, y_d;
  logic                de_q, de_d, blank_q, blank_d, vblank_q, vblank_d;
  logic                hsync_q, hsync_d, vsync_q, vsync_d, lr_q, lr_d;
  logic                fetch_q, fetch_d, fs_q, fs_d, irq_q, irq_d;
  logic [23:0]         rgb_q, rgb_d;
  logic                tp_sel, x_wrap, y_wrap, active;
  logic [23:0]         pix_src;

`ifdef VGA_TIMING_TEST_PICTURE_EN
  assign tp_sel  = test_picture;
  assign pix_src = tp_sel ? {x_q[7:0], y_q[7:0], x_q[7:0] ^ y_q[7:0]} : {r_i, g_i, b_i};
`else
  logic unused_test_picture;
  assign unused_test_picture = test_picture;
  assign tp_sel  = 1'b0;
  assign pix_src = {r_i, g_i, b_i};
`endif

  assign x_wrap = (x_q == X_LAST);
  assign y_wrap = (y_q == Y_LAST);
  assign active = (x_q < X_RES) && (y_q < Y_RES);

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    de_d     = de_q;
    blank_d  = blank_q;
    vblank_d = vblank_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    lr_d     = lr_q;
    rgb_d    = rgb_q;
    // Pulses default low so they last exactly one clk_pixel whatever the enable duty.
    fetch_d  = 1'b0;
    fs_d     = 1'b0;
    irq_d    = 1'b0;
    if (clk_pixel_ena) begin
      x_d = x_wrap ? '0 : x_q + 1'b1;
      if (x_wrap) y_d = y_wrap ? '0 : y_q + 1'b1;
      de_d     = active;
      blank_d  = !active;
      vblank_d = (y_q >= Y_RES);
      hsync_d  = ((x_q >= HS_BEG) && (x_q <= HS_END)) ? HPOL : !HPOL;
      vsync_d  = ((y_q >= VS_BEG) && (y_q <= VS_END)) ? VPOL : !VPOL;
      lr_d     = DBL_Y & y_q[0];
      rgb_d    = active ? pix_src : 24'h0;
      // With X doubling a fetched pixel covers an even/odd column pair.
      fetch_d  = active && (!DBL_X || x_q[0]) && !tp_sel;
      fs_d     = x_wrap && y_wrap;
      irq_d    = x_wrap && (y_q == Y_VBEG);
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      de_q     <= 1'b0;
      blank_q  <= 1'b1;
      vblank_q <= 1'b0;
      hsync_q  <= !HPOL;
      vsync_q  <= !VPOL;
      lr_q     <= 1'b0;
      rgb_q    <= 24'h0;
      fetch_q  <= 1'b0;
      fs_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      de_q     <= de_d;
      blank_q  <= blank_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      lr_q     <= lr_d;
      rgb_q    <= rgb_d;
      fetch_q  <= fetch_d;
      fs_q     <= fs_d;
      irq_q    <= irq_d;
    end
  end

  assign beam_x      = x_q;
  assign beam_y      = y_q;
  assign vga_de      = de_q;
  assign vga_blank   = blank_q;
  assign vga_vblank  = vblank_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign line_repeat = lr_q;
  assign fetch_next  = fetch_q;
  assign frame_start = fs_q;
  assign vblank_irq  = irq_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a 8x4 mode (frame 14x7): dut0 plain, dut1 inverted sync polarity with X/Y doubling.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_TEST_PICTURE_EN
  localparam bit TP_EN = 1'b1;
`else
  localparam bit TP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic test_picture = 1'b0;
  logic [7:0] r_in = 8'h0, g_in = 8'h0, b_in = 8'h0;

  logic        fetch0, lr0, fs0, irq0, hs0, vs0, blank0, vblank0, de0;
  logic [11:0] bx0;
  logic [10:0] by0;
  logic [7:0]  r0, g0, b0;
  logic        fetch1, lr1, fs1, irq1, hs1, vs1, blank1, vblank1, de1;
  logic [11:0] bx1;
  logic [10:0] by1;
  logic [7:0]  r1, g1, b1;

  int assertions = 0;
  int failures = 0;

  // Model state: enabled edges since reset, whether the last clk was enabled, last captured pixel.
  int          n_edges = 0;
  bit          last_en = 1'b0;
  logic [23:0] cap = 24'h0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .c_resolution_x(8), .c_hsync_front_porch(2), .c_hsync_pulse(3), .c_hsync_back_porch(1),
    .c_resolution_y(4), .c_vsync_front_porch(1), .c_vsync_pulse(1), .c_vsync_back_porch(1),
    .c_hsync_pol(1), .c_vsync_pol(1), .c_bits_x(12), .c_bits_y(11), .c_dbl_x(0), .c_dbl_y(0)
  ) dut0 (
    .clk_pixel(clk), .rst_n(rst_n), .clk_pixel_ena(ena), .test_picture(test_picture),
    .r_i(r_in), .g_i(g_in), .b_i(b_in),
    .fetch_next(fetch0), .line_repeat(lr0), .beam_x(bx0), .beam_y(by0),
    .frame_start(fs0), .vblank_irq(irq0), .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .vga_hsync(hs0), .vga_vsync(vs0), .vga_blank(blank0), .vga_vblank(vblank0), .vga_de(de0)
  );

  vga_timing_gen #(
    .c_resolution_x(8), .c_hsync_front_porch(2), .c_hsync_pulse(3), .c_hsync_back_porch(1),
    .c_resolution_y(4), .c_vsync_front_porch(1), .c_vsync_pulse(1), .c_vsync_back_porch(1),
    .c_hsync_pol(0), .c_vsync_pol(0), .c_bits_x(12), .c_bits_y(11), .c_dbl_x(1), .c_dbl_y(1)
  ) dut1 (
    .clk_pixel(clk), .rst_n(rst_n), .clk_pixel_ena(ena), .test_picture(test_picture),
    .r_i(r_in), .g_i(g_in), .b_i(b_in),
    .fetch_next(fetch1), .line_repeat(lr1), .beam_x(bx1), .beam_y(by1),
    .frame_start(fs1), .vblank_irq(irq1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hsync(hs1), .vga_vsync(vs1), .vga_blank(blank1), .vga_vblank(vblank1), .vga_de(de1)
  );

  logic [55:0] obs0, obs1;
  assign obs0 = {bx0, by0, de0, blank0, vblank0, hs0, vs0, lr0, fetch0, fs0, irq0, r0, g0, b0};
  assign obs1 = {bx1, by1, de1, blank1, vblank1, hs1, vs1, lr1, fetch1, fs1, irq1, r1, g1, b1};

  // Expected outputs from frame arithmetic: counters sit at position n, level outputs decode position n-1.
  function automatic logic [55:0] model(input int n, input bit le, input logic [23:0] pix,
                                        input bit dx, input bit dy, input bit hp, input bit vp, input bit tp);
    logic [11:0] bx;
    logic [10:0] by;
    int p, px, py;
    bit act;
    bx = 12'(n % 14);
    by = 11'((n / 14) % 7);
    if (n == 0) return {bx, by, 1'b0, 1'b1, 1'b0, !hp, !vp, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
    p = n - 1;
    px = p % 14;
    py = (p / 14) % 7;
    act = (px < 8) && (py < 4);
    return {bx, by, act, !act, py >= 4,
            (px >= 10 && px <= 12) ? hp : !hp,
            (py == 5) ? vp : !vp,
            dy && (py % 2 == 1),
            le && act && (!dx || (px % 2 == 1)) && !tp,
            le && px == 13 && py == 6,
            le && px == 13 && py == 3,
            pix};
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_edges = 0;
    last_en = 1'b0;
    cap = 24'h0;
  endtask

  // Advance the model by one clk with the inputs currently driven.
  task automatic model_edge(input bit tp);
    int px, py;
    if (ena) begin
      px = n_edges % 14;
      py = (n_edges / 14) % 7;
      if (px < 8 && py < 4) cap = tp ? {8'(px), 8'(py), 8'(px ^ py)} : {r_in, g_in, b_in};
      else cap = 24'h0;
      n_edges++;
    end
    last_en = ena;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ena = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    assertions++;
    if ({de0, blank0, vblank0, hs0, vs0, fetch0, fs0, irq0, lr0} !== 9'b010000000 || bx0 !== 12'd0 || by0 !== 11'd0) begin
      failures++;
      $display("FAIL reset_state_dut0 got de/bl/vb/hs/vs/fe/fs/irq/lr=%b bx=%0d by=%0d", {de0, blank0, vblank0, hs0, vs0, fetch0, fs0, irq0, lr0}, bx0, by0);
    end
    assertions++;
    if ({hs1, vs1, r1, g1, b1} !== {2'b11, 24'h0}) begin
      failures++;
      $display("FAIL reset_state_dut1 got hs=%b vs=%b rgb=%h expected hs=1 vs=1 rgb=0", hs1, vs1, {r1, g1, b1});
    end
    rst_n = 1'b1;
    ena = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    assertions++;
    if (bx0 !== 12'd5 || de0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_state got bx=%0d de=%b expected bx=5 de=1", bx0, de0);
    end
    rst_n = 1'b0;
    #1;
    assertions++;
    if (de0 !== 1'b0 || blank0 !== 1'b1 || hs0 !== 1'b0 || hs1 !== 1'b1 || bx0 !== 12'd0) begin
      failures++;
      $display("FAIL reset_midline got de=%b blank=%b hs0=%b hs1=%b bx=%0d expected 0 1 0 1 0", de0, blank0, hs0, hs1, bx0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    assertions++;
    if (de0 !== 1'b1 || bx0 !== 12'd1 || blank0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_edge got de=%b bx=%0d blank=%b expected de=1 bx=1 blank=0", de0, bx0, blank0);
    end
  endtask

  task automatic test_random_enable(input int cycles);
    logic [55:0] e0, e1;
    int bad = 0;
    do_reset();
    test_picture = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      e0 = model(n_edges, last_en, cap, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      e1 = model(n_edges, last_en, cap, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      assertions++;
      if (obs0 !== e0) begin
        failures++;
        if (bad++ < 10) $display("FAIL random_dut0 cyc=%0d got=%h expected=%h", i, obs0, e0);
      end
      assertions++;
      if (obs1 !== e1) begin
        failures++;
        if (bad++ < 10) $display("FAIL random_dut1 cyc=%0d got=%h expected=%h", i, obs1, e1);
      end
      ena = ($urandom_range(0, 3) != 0);
      r_in = 8'($urandom);
      g_in = 8'($urandom);
      b_in = 8'($urandom);
      model_edge(1'b0);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_periods;
    bit got = 1'b0;
    int cyc = 0, f0 = 0, f1 = 0, i0 = 0, i1 = 0, de_c = 0, hs0_c = 0, hs1_c = 0;
    int vb_c = 0, vs0_c = 0, vs1_c = 0, lr_c = 0, lr0_c = 0;
    ena = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (fs0) got = 1'b1;
    end
    assertions++;
    if (!got) begin
      failures++;
      $display("FAIL periods_sync got no frame_start within 300 clk");
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      cyc++;
      f0 += int'(fetch0);
      f1 += int'(fetch1);
      i0 += int'(irq0);
      i1 += int'(irq1);
      de_c += int'(de0);
      hs0_c += int'(hs0);
      hs1_c += int'(!hs1);
      vb_c += int'(vblank0);
      vs0_c += int'(vs0);
      vs1_c += int'(!vs1);
      lr_c += int'(lr1 && de1);
      lr0_c += int'(lr0);
      if (fs0) got = 1'b1;
    end
    assertions++;
    if (cyc != 98 || !got) begin failures++; $display("FAIL frame_period got=%0d expected=98", cyc); end
    assertions++;
    if (f0 != 32 || f1 != 16) begin failures++; $display("FAIL fetch_count got dut0=%0d dut1=%0d expected 32 16", f0, f1); end
    assertions++;
    if (i0 != 1 || i1 != 1) begin failures++; $display("FAIL vblank_irq_count got dut0=%0d dut1=%0d expected 1 1", i0, i1); end
    assertions++;
    if (de_c != 32) begin failures++; $display("FAIL de_clocks got=%0d expected=32", de_c); end
    assertions++;
    if (hs0_c != 21 || hs1_c != 21) begin failures++; $display("FAIL hsync_clocks got dut0=%0d dut1=%0d expected 21 21", hs0_c, hs1_c); end
    assertions++;
    if (vb_c != 42) begin failures++; $display("FAIL vblank_clocks got=%0d expected=42", vb_c); end
    assertions++;
    if (vs0_c != 14 || vs1_c != 14) begin failures++; $display("FAIL vsync_clocks got dut0=%0d dut1=%0d expected 14 14", vs0_c, vs1_c); end
    assertions++;
    if (lr_c != 16 || lr0_c != 0) begin failures++; $display("FAIL line_repeat_clocks got dut1=%0d dut0=%0d expected 16 0", lr_c, lr0_c); end
  endtask

  task automatic test_back_to_back;
    bit got = 1'b0;
    bit prev = 1'b0;
    int cyc = 0, f0 = 0, dbl = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (fs0) got = 1'b1;
      ena = !ena;
    end
    assertions++;
    if (!got) begin failures++; $display("FAIL alt_sync got no frame_start within 600 clk"); end
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      cyc++;
      f0 += int'(fetch0);
      if (fetch0 && prev) dbl++;
      prev = fetch0;
      if (fs0) got = 1'b1;
      ena = !ena;
    end
    assertions++;
    if (cyc != 196 || !got) begin failures++; $display("FAIL alt_frame_period got=%0d expected=196", cyc); end
    assertions++;
    if (f0 != 32 || dbl != 0) begin failures++; $display("FAIL alt_fetch got pulses=%0d wide=%0d expected 32 0", f0, dbl); end
  endtask

  task automatic test_picture_mode;
    logic [55:0] e0, e1;
    int bad = 0;
    bit tp = TP_EN;
    do_reset();
    test_picture = 1'b1;
    for (int i = 0; i < 110; i++) begin
      e0 = model(n_edges, last_en, cap, 1'b0, 1'b0, 1'b1, 1'b1, tp);
      e1 = model(n_edges, last_en, cap, 1'b1, 1'b1, 1'b0, 1'b0, tp);
      assertions++;
      if (obs0 !== e0 || obs1 !== e1) begin
        failures++;
        if (bad++ < 10) $display("FAIL picture cyc=%0d got0=%h exp0=%h got1=%h exp1=%h", i, obs0, e0, obs1, e1);
      end
`ifdef VGA_TIMING_TEST_PICTURE_EN
      if (n_edges == 2 * 14 + 3 + 1) begin
        assertions++;
        if ({r0, g0, b0} !== 24'h030201) begin
          failures++;
          $display("FAIL picture_pixel_3_2 got=%h expected=030201", {r0, g0, b0});
        end
      end
`endif
      ena = 1'b1;
      r_in = 8'($urandom);
      g_in = 8'($urandom);
      b_in = 8'($urandom);
      model_edge(tp);
      @(posedge clk);
      @(negedge clk);
    end
    test_picture = 1'b0;
  endtask

  initial begin
    test_reset();
    test_random_enable(700);
    test_periods();
    test_back_to_back();
    test_picture_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
